// File: rtl/enc_cfg_pkg.sv
// Shared types and default constants for the encoder-driven parameter controller.
package enc_cfg_pkg;

  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } enc_state_e;

  localparam int unsigned PARAM_MAX_DEF   = 200;
  localparam int unsigned TIMEOUT_CYC_DEF = 60_000_000;
  localparam int unsigned FAST_CYC_DEF    = 600_000;

  localparam int unsigned STEP_DELTA_SLOW = 1;
  localparam int unsigned STEP_DELTA_FAST = 4;

endpackage

// File: rtl/encoder_param_ctrl_sat_updown.sv
// Combinational saturating add/sub of a step delta, clamped to 0..MAXV.
module sat_updown #(
  parameter int unsigned PW   = 8,
  parameter int unsigned MAXV = 200
) (
  input  logic [PW-1:0] i_value,
  input  logic [PW-1:0] i_delta,
  input  logic          i_up,
  input  logic          i_dn,
  output logic [PW-1:0] o_value
);

  localparam logic [PW:0] LIM = (PW+1)'(MAXV);

  logic [PW:0] w_sum;
  logic [PW:0] w_dif;

  // One extra bit catches both overflow past the bound and borrow below zero
  assign w_sum = {1'b0, i_value} + {1'b0, i_delta};
  assign w_dif = {1'b0, i_value} - {1'b0, i_delta};

  always_comb begin
    o_value = i_value;
    if (i_up && !i_dn) begin
      o_value = (w_sum > LIM) ? LIM[PW-1:0] : w_sum[PW-1:0];
    end else if (i_dn && !i_up) begin
      o_value = w_dif[PW] ? '0 : w_dif[PW-1:0];
    end
  end

endmodule

// File: rtl/encoder_param_ctrl.sv
// Encoder/key driven browse-edit-commit controller for a bank of config parameters.
// Build option: define ENC_ACCEL_EN to enable fast-spin step acceleration while editing.
//
//   state  | meaning
//   BROWSE | encoder moves sel (wrapping); key opens the selected parameter
//   EDIT   | encoder adjusts shadow value (saturating); key commits; idle abandons
//   COMMIT | single cycle: shadow written to bank, strobe issued on next edge
module encoder_param_ctrl
  import enc_cfg_pkg::*;
#(
  parameter int unsigned NUM_PARAMS  = 4,
  parameter int unsigned PW          = 8,
  parameter int unsigned PARAM_MAX   = PARAM_MAX_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned FAST_CYC    = FAST_CYC_DEF,
  localparam int unsigned SW         = $clog2(NUM_PARAMS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_cw,
  input  logic                     step_ccw,
  input  logic                     key_press,
  output logic [SW-1:0]            sel,
  output logic                     edit_mode,
  output logic [PW-1:0]            edit_value,
  output logic [NUM_PARAMS*PW-1:0] param_flat,
  output logic                     cfg_update,
  output logic [SW-1:0]            cfg_index
);

  localparam int unsigned TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(NUM_PARAMS - 1);

  enc_state_e r_state;
  enc_state_e w_state_nx;

  logic [SW-1:0] r_sel;
  logic [PW-1:0] r_edit_value;
  logic [PW-1:0] r_param [NUM_PARAMS];
  logic          r_cfg_update;
  logic [SW-1:0] r_cfg_index;
  logic [TW-1:0] r_to_cnt;

  logic          w_cw;
  logic          w_ccw;
  logic          w_enter_edit;
  logic          w_edit_step;
  logic          w_timeout;
  logic [PW-1:0] w_delta;
  logic [PW-1:0] w_sat_value;

  // A key wins over any step; opposing steps in one cycle cancel
  assign w_cw  = step_cw  && !step_ccw && !key_press;
  assign w_ccw = step_ccw && !step_cw  && !key_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BROWSE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_enter_edit = 1'b0;
    w_edit_step  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      BROWSE: begin
        if (key_press) begin
          w_state_nx   = EDIT;
          w_enter_edit = 1'b1;
        end
      end
      EDIT: begin
        if (key_press) begin
          w_state_nx = COMMIT;
        end else if (w_cw || w_ccw) begin
          w_edit_step = 1'b1;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nx = BROWSE;
          w_timeout  = 1'b1;
        end
      end
      COMMIT: begin
        w_state_nx = BROWSE;
      end
      default: begin
        w_state_nx = BROWSE;
      end
    endcase
  end

`ifdef ENC_ACCEL_EN
  localparam int unsigned FCW     = $clog2(FAST_CYC + 1);
  localparam logic [FCW-1:0] GAP_SAT = FCW'(FAST_CYC);

  logic [FCW-1:0] r_gap_cnt;

  // Cycles since the previous edit step; a fresh edit starts saturated so its first step is slow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= GAP_SAT;
    end else if (w_enter_edit) begin
      r_gap_cnt <= GAP_SAT;
    end else if (w_edit_step) begin
      r_gap_cnt <= FCW'(1);
    end else if (r_gap_cnt != GAP_SAT) begin
      r_gap_cnt <= r_gap_cnt + FCW'(1);
    end
  end

  assign w_delta = (r_gap_cnt < GAP_SAT) ? PW'(STEP_DELTA_FAST) : PW'(STEP_DELTA_SLOW);
`else
  assign w_delta = PW'(STEP_DELTA_SLOW);
`endif

  sat_updown #(
    .PW   (PW),
    .MAXV (PARAM_MAX)
  ) u_sat (
    .i_value (r_edit_value),
    .i_delta (w_delta),
    .i_up    (w_cw),
    .i_dn    (w_ccw),
    .o_value (w_sat_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
    end else if (r_state == BROWSE) begin
      if (w_cw) begin
        r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + SW'(1);
      end else if (w_ccw) begin
        r_sel <= (r_sel == '0) ? SEL_LAST : r_sel - SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edit_value <= '0;
    end else if (w_enter_edit) begin
      r_edit_value <= r_param[r_sel];
    end else if (w_edit_step) begin
      r_edit_value <= w_sat_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state != EDIT || key_press || w_cw || w_ccw || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Bank write and strobe land on the same edge, so consumers see the new value with cfg_update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        r_param[i] <= '0;
      end
      r_cfg_update <= 1'b0;
      r_cfg_index  <= '0;
    end else begin
      r_cfg_update <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_param[r_sel] <= r_edit_value;
        r_cfg_index    <= r_sel;
      end
    end
  end

  always_comb begin
    param_flat = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      param_flat[i*PW +: PW] = r_param[i];
    end
  end

  assign sel        = r_sel;
  assign edit_mode  = (r_state == EDIT);
  assign edit_value = r_edit_value;
  assign cfg_update = r_cfg_update;
  assign cfg_index  = r_cfg_index;

endmodule
